// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//
// Data-side memory and peripheral responder for a single-cycle CPU. It provides
// a word-addressed RAM, a free-running CYCLE counter, and a byte-wide TX FIFO
// with a STATUS register. Loads are answered combinationally in the same cycle.
//
// Address map (bits [1:0] ignored):
//   0x0000_0000 .. DEPTH_WORDS*4-1 : RAM
//   0x1000_0000                    : CYCLE  (read/write, increments every cycle)
//   0x1000_0004                    : TXDATA (write pushes data_i[7:0], reads 0)
//   0x1000_0008                    : STATUS (bit0 empty, bit1 full, bit2 overflow,
//                                            bits[7:4] count; write bit2=1 clears
//                                            overflow)
//   anything else                  : unmapped (writes dropped, reads 0)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   data_ce_i    CPU access enable
//   data_we_i    CPU write enable (qualified by data_ce_i)
//   data_addr_i  CPU byte address
//   data_i       CPU store data
//   data_o       CPU load data (0 unless a read is in progress)
//   tx_valid_o   FIFO head valid
//   tx_data_o    FIFO head byte (0 while empty)
//   tx_ready_i   downstream accepts the head byte
// -----------------------------------------------------------------------------
module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Word addresses (byte address >> 2) of the peripheral registers.
    localparam logic [29:0] CYCLE_WORD  = 30'h0400_0000;
    localparam logic [29:0] TXDATA_WORD = 30'h0400_0001;
    localparam logic [29:0] STATUS_WORD = 30'h0400_0002;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_TXDATA,
        SEL_STATUS
    } sel_e;

    sel_e sel;

    // The byte-lane bits never influence the decode.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^data_addr_i[1:0];

    always_comb begin
        sel = SEL_NONE;
        if (data_addr_i[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else if (data_addr_i[31:2] == CYCLE_WORD) begin
            sel = SEL_CYCLE;
        end else if (data_addr_i[31:2] == TXDATA_WORD) begin
            sel = SEL_TXDATA;
        end else if (data_addr_i[31:2] == STATUS_WORD) begin
            sel = SEL_STATUS;
        end
    end

    // CPU writes are suppressed during a reset cycle.
    logic wr_en;
    logic rd_en;
    assign wr_en = data_ce_i & data_we_i & ~rst;
    assign rd_en = data_ce_i & ~data_we_i;

    // -------------------------------------------------------------------------
    // RAM
    // -------------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    assign ram_idx = data_addr_i[AW+1:2];

    // NOTE: storage arrays carry no reset; clearing them would turn the array
    // into thousands of resettable flops instead of a RAM macro, and rst must
    // leave RAM contents intact anyway.
    always_ff @(posedge clk) begin
        if (wr_en && sel == SEL_RAM) begin
            mem_q[ram_idx] <= data_i;
        end
    end

    // -------------------------------------------------------------------------
    // CYCLE counter: a CPU write wins over the increment.
    // -------------------------------------------------------------------------
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (wr_en && sel == SEL_CYCLE) begin
            cycle_d = data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;

    logic fifo_empty;
    logic fifo_full;
    logic push_req;
    logic push;
    logic pop;
    logic ovf_set;
    logic ovf_clr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

    assign push_req = wr_en && sel == SEL_TXDATA;
    assign pop      = ~fifo_empty & tx_ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign push     = push_req & (~fifo_full | pop);
    assign ovf_set  = push_req & fifo_full & ~pop;
    assign ovf_clr  = wr_en && sel == SEL_STATUS && data_i[2];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // A new overflow outranks a clear arriving in the same cycle.
        ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx_valid_o = ~fifo_empty;
    assign tx_data_o  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

    // -------------------------------------------------------------------------
    // Load data
    // -------------------------------------------------------------------------
    logic [3:0]  count4;
    logic [31:0] status_word;
    assign count4      = 4'(count_q);
    assign status_word = {24'h0, count4, 1'b0, ovf_q, fifo_full, fifo_empty};

    always_comb begin
        data_o = '0;
        if (rd_en) begin
            unique case (sel)
                SEL_RAM:    data_o = mem_q[ram_idx];
                SEL_CYCLE:  data_o = cycle_q;
                SEL_STATUS: data_o = status_word;
                default:    data_o = '0;
            endcase
        end
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024 (power of 2): RAM size in 32-bit words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, at most 8): TX FIFO entries.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port data_ce_i, input, 1: access enable from the CPU data port.
REQ-006 SHALL have port data_we_i, input, 1: write enable, qualified by data_ce_i.
REQ-007 SHALL have port data_addr_i, input, 32: byte address, with bits [1:0] ignored.
REQ-008 SHALL have port data_i, input, 32: store data from the CPU.
REQ-009 SHALL have port data_o, output, 32: load data to the CPU.
REQ-010 SHALL have port tx_valid_o, output, 1: FIFO head valid.
REQ-011 SHALL have port tx_data_o, output, 8: FIFO head byte.
REQ-012 SHALL have port tx_ready_i, input, 1: downstream accepts the head byte.

Function
REQ-013 SHALL decode the address map: RAM at 0x0000_0000 to DEPTH_WORDS*4-1; CYCLE at 0x1000_0000; TXDATA at 0x1000_0004; STATUS at 0x1000_0008; every other address is unmapped.
REQ-014 SHALL drive data_o combinationally in the same cycle, because the CPU is single-cycle: mapped read value when data_ce_i=1 and data_we_i=0, otherwise 0.
REQ-015 SHALL write the RAM word at index addr[log2(DEPTH_WORDS)+1:2] on the clock edge when data_ce_i=1, data_we_i=1 and the address is in RAM range.
REQ-016 SHALL return the RAM contents of the previous edge on a RAM read, with no write-through in the same cycle.
REQ-017 SHALL ignore writes to unmapped addresses and return 0 on reads from them.
REQ-018 SHALL increment the 32-bit CYCLE counter every cycle, wrapping from 0xFFFF_FFFF to 0.
REQ-019 SHALL load data_i into CYCLE on a CYCLE write, with the write taking precedence over the increment.
REQ-020 SHALL push data_i[7:0] into the FIFO on a TXDATA write; TXDATA reads return 0.
REQ-021 SHALL drop a push when the FIFO is full and no pop occurs that cycle, and SHALL set the sticky overflow flag in that case.
REQ-022 SHALL accept a push while full when a pop occurs in the same cycle; count is unchanged and overflow is not set.
REQ-023 SHALL pop on an edge where tx_valid_o=1 and tx_ready_i=1.
REQ-024 SHALL hold tx_valid_o=1 exactly when count is greater than 0, with tx_data_o equal to the oldest entry, stable until popped.
REQ-025 SHALL apply a simultaneous push and pop when count is between 1 and FIFO_DEPTH-1: both take effect and count is unchanged.
REQ-026 SHALL not bypass a push into an empty FIFO: the byte is visible on tx_valid_o the next cycle.
REQ-027 SHALL ignore tx_ready_i when the FIFO is empty; no pop occurs and no state changes.
REQ-028 SHALL wrap read and write pointers modulo FIFO_DEPTH, and count SHALL range from 0 to FIFO_DEPTH.
REQ-029 SHALL read STATUS as: bit0 empty, bit1 full, bit2 overflow, bits[7:4] count, all other bits 0.
REQ-030 SHALL clear overflow on a STATUS write with data_i[2]=1; other STATUS write bits are ignored.
REQ-031 SHALL keep overflow set if a clear and a new overflow occur in the same cycle.

Reset
REQ-032 SHALL, on an edge with rst=1: CYCLE=0, FIFO pointers=0, count=0, overflow=0, tx_valid_o=0.
REQ-033 SHALL drive tx_data_o=0 while the FIFO is empty.
REQ-034 SHALL leave RAM contents unchanged by rst.
REQ-035 SHALL ignore CPU accesses during a reset cycle: writes are dropped and data_o behaves as in REQ-014.
REQ-036 SHALL discard all FIFO contents when rst is asserted mid-stream.
REQ-037 SHALL restart CYCLE from 0 when rst is asserted mid-count.

Verification
REQ-038 SHALL cover a RAM round trip: write 0xDEAD_BEEF to 0x0000_0010, read 0x0000_0013 next cycle -> data_o=0xDEAD_BEEF; read 0x0000_2000 -> 0.
REQ-039 SHALL cover the counter: release rst, idle 5 cycles -> CYCLE read 5; write 0xFFFF_FFFF, read 1 cycle later -> 0.
REQ-040 SHALL cover FIFO overflow: tx_ready_i=0, push 0x41..0x45 -> first 4 stored, STATUS=0x0000_0046; write 4 to STATUS -> 0x0000_0042.
REQ-041 SHALL cover the drain: tx_ready_i=1 after REQ-040 -> tx_data_o sequence 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid_o=0 and STATUS=0x0000_0001.
REQ-042 SHALL cover push while full with a pop: FIFO full, tx_ready_i=1, push 0x5A -> count stays 4, overflow 0, 0x5A emitted 4th.
REQ-043 SHALL cover mid-stream reset: 3 bytes queued, pulse rst for 1 cycle -> tx_valid_o=0, STATUS=0x0000_0001, earlier RAM write still reads back.
